// File: rtl/xsm_capture_buffer.sv
// Triggered ADC capture buffer: circular pre/post-trigger storage with a
// valid/ready readout of one DEPTH-sample frame, oldest sample first.
module xsm_capture_buffer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned PRE_TRIG     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] vin_adc,
  input  logic                    adc_valid,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trigger_in,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_last,
  output logic [47:0]             mono_counter,
  output logic [47:0]             trig_timestamp,
  output logic [15:0]             frame_count,
  output logic [2:0]              state_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned TSW = 48;
  localparam int unsigned FCW = 16;

  // Terminal counts for the pre-fill, post-trigger and readout phases.
  localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'((DEPTH - PRE_TRIG >= 2) ? DEPTH - PRE_TRIG - 2 : 0);
  localparam logic [AW-1:0] BEAT_LAST = AW'(DEPTH - 1);
  localparam bit            NO_PRE    = (PRE_TRIG == 0);
  localparam bit            NO_POST   = (PRE_TRIG == DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READ    = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [TSW-1:0]          mono_q, mono_d;
  logic [TSW-1:0]          trig_ts_q, trig_ts_d;
  logic [FCW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic                    trig_pend_q, trig_pend_d;
  logic                    trigger_q, trigger_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic [SAMPLE_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];

  logic wr_en_c;
  logic edge_c;
  logic enter_read_c;

  // Rising edge of the trigger level against last cycle's sample.
  assign edge_c = trigger_in & ~trigger_q;

  // Next-state, pointer, counter and readout logic.
  always_comb begin
    state_d      = state_q;
    mono_d       = mono_q + TSW'(1);
    trig_ts_d    = trig_ts_q;
    frame_cnt_d  = frame_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    trig_pend_d  = trig_pend_q;
    trigger_d    = trigger_in;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    rd_data_d    = rd_data_q;
    wr_en_c      = 1'b0;
    enter_read_c = 1'b0;

    if (abort) begin
      state_d     = S_IDLE;
      trig_pend_d = 1'b0;
      cnt_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            cnt_d       = '0;
            trig_pend_d = 1'b0;
            state_d     = NO_PRE ? S_ARMED : S_PREFILL;
          end
        end

        S_PREFILL: begin
          if (adc_valid) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + AW'(1);
            if (cnt_q == PRE_LAST) begin
              cnt_d   = '0;
              state_d = S_ARMED;
            end
          end
        end

        S_ARMED: begin
          if (edge_c && !trig_pend_q) begin
            trig_ts_d = mono_q;
          end
          if (adc_valid) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (edge_c || trig_pend_q) begin
              trig_pend_d = 1'b0;
              cnt_d       = '0;
              if (NO_POST) begin
                enter_read_c = 1'b1;
              end else begin
                state_d = S_POST;
              end
            end
          end else if (edge_c) begin
            trig_pend_d = 1'b1;
          end
        end

        S_POST: begin
          if (adc_valid) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + AW'(1);
            if (cnt_q == POST_LAST) begin
              enter_read_c = 1'b1;
            end
          end
        end

        S_READ: begin
          if (rd_valid_q && rd_ready) begin
            if (rd_last_q) begin
              state_d     = S_IDLE;
              frame_cnt_d = frame_cnt_q + FCW'(1);
              rd_valid_d  = 1'b0;
              rd_last_d   = 1'b0;
              cnt_d       = '0;
            end else begin
              rd_ptr_d  = rd_ptr_q + AW'(1);
              rd_data_d = mem_q[rd_ptr_d];
              cnt_d     = cnt_q + AW'(1);
              rd_last_d = ((cnt_q + AW'(1)) == BEAT_LAST);
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // The oldest sample sits just past the final write; that slot is not
      // written this cycle, so the current array contents are safe to read.
      if (enter_read_c) begin
        state_d    = S_READ;
        rd_ptr_d   = wr_ptr_q + AW'(1);
        rd_data_d  = mem_q[rd_ptr_d];
        rd_valid_d = 1'b1;
        rd_last_d  = 1'b0;
        cnt_d      = '0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mono_q      <= '0;
      trig_ts_q   <= '0;
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      trig_pend_q <= 1'b0;
      trigger_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mono_q      <= mono_d;
      trig_ts_q   <= trig_ts_d;
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      trig_pend_q <= trig_pend_d;
      trigger_q   <= trigger_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Sample storage; contents are don't-care until overwritten by a capture.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= vin_adc;
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign rd_last        = rd_last_q;
  assign mono_counter   = mono_q;
  assign trig_timestamp = trig_ts_q;
  assign frame_count    = frame_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_xsm_capture_buffer.sv
// Directed bench for xsm_capture_buffer (DEPTH=8, PRE_TRIG=3) with a frame
// scoreboard filled at capture time and drained on readout handshakes.
module tb_xsm_capture_buffer;

  localparam int unsigned SW  = 16;
  localparam int unsigned DEP = 8;
  localparam int unsigned PRE = 3;

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] vin_adc;
  logic          adc_valid;
  logic          arm;
  logic          abort;
  logic          trigger_in;
  logic          rd_ready;
  logic          rd_valid;
  logic [SW-1:0] rd_data;
  logic          rd_last;
  logic [47:0]   mono_counter;
  logic [47:0]   trig_timestamp;
  logic [15:0]   frame_count;
  logic [2:0]    state_o;

  int n_vec = 0;
  int n_err = 0;

  logic [SW-1:0] sb [$];
  logic [47:0]   tb_mono;

  xsm_capture_buffer #(
    .SAMPLE_WIDTH(SW),
    .DEPTH       (DEP),
    .PRE_TRIG    (PRE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vin_adc       (vin_adc),
    .adc_valid     (adc_valid),
    .arm           (arm),
    .abort         (abort),
    .trigger_in    (trigger_in),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .mono_counter  (mono_counter),
    .trig_timestamp(trig_timestamp),
    .frame_count   (frame_count),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timebase: counts rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_mono <= '0;
    else        tb_mono <= tb_mono + 48'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm, stream a 0x100+k ramp and raise the trigger at edge_k. pulse_k adds a
  // single-cycle trigger pulse earlier; gap puts the edge in a no-sample cycle.
  task automatic capture_ramp(input int edge_k, input int pulse_k, input bit gap,
                              output logic [47:0] ts);
    ts         = '0;
    arm        = 1'b1;
    trigger_in = 1'b0;
    adc_valid  = 1'b0;
    tick();
    arm = 1'b0;
    chk("arm_state", state_o, 64'd1);
    for (int k = 0; k <= edge_k + 4; k++) begin
      if (gap && k == edge_k) begin
        adc_valid  = 1'b0;
        trigger_in = 1'b1;
        ts         = tb_mono;
        tick();
        chk("gap_state", state_o, 64'd2);
      end
      adc_valid  = 1'b1;
      vin_adc    = 16'(16'h100 + k);
      trigger_in = (k == pulse_k) || (k >= edge_k);
      arm        = (k == edge_k - 1);
      if (!gap && k == edge_k) ts = tb_mono;
      tick();
      if (k == int'(PRE) - 1) chk("prefill_done", state_o, 64'd2);
      if (k == edge_k)        chk("post_entry", state_o, 64'd3);
    end
    arm        = 1'b0;
    adc_valid  = 1'b0;
    trigger_in = 1'b0;
    chk("read_entry", state_o, 64'd4);
    for (int i = 0; i < int'(DEP); i++) sb.push_back(16'(16'h100 + edge_k - int'(PRE) + i));
  endtask

  // Drain one frame against the scoreboard, optionally with a random sink.
  task automatic read_frame(input bit rnd);
    int beats = 0;
    bit done  = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("extra_beat", rd_valid, 64'd0);
          done = 1'b1;
        end else begin
          chk("rd_data", rd_data, sb[0]);
          chk("rd_last", rd_last, sb.size() == 1);
          rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (rd_ready) begin
            void'(sb.pop_front());
            beats++;
            if (sb.size() == 0) done = 1'b1;
          end
        end
      end else begin
        rd_ready = 1'b0;
        if (beats > 0) chk("valid_drop", rd_valid, 64'd1);
      end
      tick();
    end
    rd_ready = 1'b0;
    chk("beats", beats, 64'(DEP));
    chk("sb_empty", sb.size(), 64'd0);
    chk("done_valid", rd_valid, 64'd0);
    chk("done_state", state_o, 64'd0);
    sb.delete();
  endtask

  initial begin
    logic [47:0] ts;
    logic [47:0] abort_ts;
    rst_n      = 1'b0;
    vin_adc    = '0;
    adc_valid  = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;
    trigger_in = 1'b0;
    rd_ready   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rd_valid, 64'd0);
    chk("rst_last", rd_last, 64'd0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_mono", mono_counter, 64'd0);
    chk("rst_ts", trig_timestamp, 64'd0);
    chk("rst_fc", frame_count, 64'd0);
    chk("rst_state", state_o, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mono_1", mono_counter, 64'd1);
    tick();
    chk("mono_2", mono_counter, 64'd2);
    tick();
    chk("mono_3", mono_counter, 64'd3);
    chk("idle_state", state_o, 64'd0);

    // Basic capture: edge on k=10, frame 0x107..0x10E.
    capture_ramp(10, -1, 1'b0, ts);
    chk("ts_basic", trig_timestamp, ts);
    read_frame(1'b0);
    chk("fc_1", frame_count, 64'd1);

    // Edge in PREFILL ignored; edge at k=5 triggers; random sink.
    capture_ramp(5, 1, 1'b0, ts);
    chk("ts_prefill", trig_timestamp, ts);
    read_frame(1'b1);
    chk("fc_2", frame_count, 64'd2);

    // Edge in a cycle without a sample; next sample 0x10A is the trigger.
    capture_ramp(10, -1, 1'b1, ts);
    chk("ts_gap", trig_timestamp, ts);
    read_frame(1'b1);
    chk("fc_3", frame_count, 64'd3);

    // Abort during POST.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    abort_ts = '0;
    for (int k = 0; k <= 12; k++) begin
      adc_valid  = 1'b1;
      vin_adc    = 16'(16'h100 + k);
      trigger_in = (k >= 10);
      if (k == 10) abort_ts = tb_mono;
      tick();
    end
    chk("pre_abort_state", state_o, 64'd3);
    abort   = 1'b1;
    vin_adc = 16'h10D;
    tick();
    abort = 1'b0;
    chk("abort_state", state_o, 64'd0);
    chk("abort_valid", rd_valid, 64'd0);
    for (int k = 0; k < 10; k++) begin
      adc_valid  = 1'b1;
      vin_adc    = 16'(16'h200 + k);
      trigger_in = k[0];
      rd_ready   = 1'b1;
      tick();
      chk("abort_idle_valid", rd_valid, 64'd0);
    end
    adc_valid  = 1'b0;
    trigger_in = 1'b0;
    rd_ready   = 1'b0;
    chk("abort_idle_state", state_o, 64'd0);
    chk("abort_fc", frame_count, 64'd3);
    chk("abort_ts", trig_timestamp, abort_ts);

    // Re-arm after abort captures normally.
    capture_ramp(10, -1, 1'b0, ts);
    chk("ts_rearm", trig_timestamp, ts);
    read_frame(1'b1);
    chk("fc_4", frame_count, 64'd4);
    chk("mono_track", mono_counter, tb_mono);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
